// File: rtl/adc_capture_pkg.sv
// Shared types and defaults for the ADC capture path.
package adc_capture_pkg;

  localparam int unsigned NCH_DEF   = 6;
  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    ARMED,
    CAPTURE,
    DRAIN
  } state_t;

endpackage

// File: rtl/trig_edge_det.sv
// Rising-edge detector for the external trigger level.
module trig_edge_det (
  input  logic clk,
  input  logic rstn,
  input  logic trig_in,
  output logic rise
);

  logic trig_q;

  always_ff @(posedge clk) begin
    if (!rstn) trig_q <= 1'b0;
    else       trig_q <= trig_in;
  end

  assign rise = trig_in & ~trig_q;

endmodule

// File: rtl/capture_sequencer.sv
// Sequences one capture frame: flush FIFOs, wait for trigger, write len_q
// samples per enabled channel, then hold cap_done until the reader drains.
module capture_sequencer
  import adc_capture_pkg::*;
#(
  parameter int unsigned NCH       = NCH_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF,
  parameter int unsigned FLUSH_CYC = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             arm,
  input  logic             abort,
  input  logic             auto_rearm,
  input  logic             trig_in,
  input  logic             sw_trig,
  input  logic [NCH-1:0]   ch_en,
  input  logic [CNT_W-1:0] cap_len,
  input  logic             sample_valid,
  input  logic [NCH-1:0]   fifo_full,
  input  logic [NCH-1:0]   fifo_empty,
  output logic [NCH-1:0]   wr_en,
  output logic             fifo_rst,
  output logic             cap_done,
  output logic             busy,
  output logic             ovf_err,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int unsigned FL_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  state_t           state;
  logic [NCH-1:0]   ch_en_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] smp_cnt;
  logic [FL_W-1:0]  fl_cnt;

  logic trig_rise;
  logic trig;
  logic last_smp;
  logic ovf_hit;
  logic drained;

  trig_edge_det u_trig (
    .clk     (clk),
    .rstn    (rstn),
    .trig_in (trig_in),
    .rise    (trig_rise)
  );

  // sw_trig and a trig_in edge in the same cycle collapse into one trigger
  assign trig     = sw_trig | trig_rise;
  assign last_smp = (smp_cnt == len_q - CNT_W'(1));
  assign ovf_hit  = sample_valid & (|(ch_en_q & fifo_full));
  assign drained  = ((fifo_empty & ch_en_q) == ch_en_q);

  // Writes are combinational off sample_valid; rstn/abort gate them the same cycle
  always_comb begin
    wr_en = '0;
    if (rstn && !abort && state == CAPTURE && sample_valid)
      wr_en = ch_en_q & ~fifo_full;
  end

  assign fifo_rst = rstn && (state == FLUSH);
  assign cap_done = rstn && (state == DRAIN);
  assign busy     = rstn && (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      ch_en_q   <= '0;
      len_q     <= '0;
      smp_cnt   <= '0;
      fl_cnt    <= '0;
      frame_cnt <= '0;
      ovf_err   <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (arm && cap_len != '0 && ch_en != '0) begin
            ch_en_q <= ch_en;
            len_q   <= cap_len;
            ovf_err <= 1'b0;
            fl_cnt  <= '0;
            state   <= FLUSH;
          end
        end
        FLUSH: begin
          if (fl_cnt == FL_W'(FLUSH_CYC - 1)) state <= ARMED;
          else                                 fl_cnt <= fl_cnt + FL_W'(1);
        end
        ARMED: begin
          if (trig) begin
            smp_cnt <= '0;
            state   <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (sample_valid) begin
            smp_cnt <= smp_cnt + CNT_W'(1);
            if (ovf_hit)  ovf_err <= 1'b1;
            if (last_smp) state   <= DRAIN;
          end
        end
        DRAIN: begin
          if (drained) begin
            frame_cnt <= frame_cnt + CNT_W'(1);
            state     <= auto_rearm ? ARMED : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/capture_sequencer.md
CAPTURE_SEQUENCER -- requirements
Module: capture_sequencer

Interface
REQ-001 Parameter NCH, default 6, SHALL set the number of channel FIFOs sequenced.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of the sample and frame counters.
REQ-003 Parameter FLUSH_CYC, default 4, SHALL set the number of cycles fifo_rst is held.
REQ-004 clk  in  1  SHALL be the single clock for all logic.
REQ-005 rstn  in  1  SHALL be the reset, synchronous, active-low.
REQ-006 arm  in  1  SHALL be a single-cycle pulse that starts a capture sequence.
REQ-007 abort  in  1  SHALL be a pulse that returns the block to IDLE.
REQ-008 auto_rearm  in  1  SHALL select continuous capture (1) or single-shot capture (0).
REQ-009 trig_in  in  1  SHALL be the external trigger level, acted on at its rising edge.
REQ-010 sw_trig  in  1  SHALL be a software trigger pulse.
REQ-011 ch_en  in  NCH  SHALL be the channel enable mask, latched into ch_en_q on arm.
REQ-012 cap_len  in  CNT_W  SHALL be the samples per channel per frame, latched into len_q on arm.
REQ-013 sample_valid  in  1  SHALL be the ADC sample strobe.
REQ-014 fifo_full, fifo_empty  in  NCH each  SHALL be the per-channel FIFO flags.
REQ-015 wr_en  out  NCH  SHALL be the per-channel FIFO write enables.
REQ-016 fifo_rst  out  1  SHALL be the FIFO flush strobe.
REQ-017 cap_done  out  1  SHALL be the frame-ready level handed to the read-side controller.
REQ-018 busy, ovf_err  out  1 each  SHALL indicate state != IDLE and a sticky overflow, respectively.
REQ-019 frame_cnt  out  CNT_W  SHALL count completed frames.

Function
REQ-020 The FSM SHALL have the states IDLE, FLUSH, ARMED, CAPTURE and DRAIN.
REQ-021 IDLE: arm with cap_len!=0 and ch_en!=0 SHALL latch ch_en_q and len_q, clear ovf_err, and go to FLUSH; arm with a zero cap_len or zero ch_en SHALL be ignored.
REQ-022 FLUSH: fifo_rst SHALL be 1 for exactly FLUSH_CYC cycles, after which the FSM SHALL go to ARMED.
REQ-023 ARMED: the trigger condition SHALL be sw_trig OR (trig_in AND NOT trig_q), where trig_q is trig_in registered every cycle; the trigger condition SHALL move the FSM to CAPTURE and clear the sample count.
REQ-024 Trigger edges occurring in IDLE, FLUSH, CAPTURE or DRAIN SHALL be ignored and not queued.
REQ-025 CAPTURE: wr_en[i] SHALL equal sample_valid AND ch_en_q[i] AND NOT fifo_full[i], combinationally, with zero latency.
REQ-026 CAPTURE: the sample count SHALL increment on every sample_valid, whether or not writes were suppressed.
REQ-027 CAPTURE: sample_valid when the count equals len_q-1 SHALL write that sample and move the FSM to DRAIN, so exactly len_q strobes are written per enabled channel.
REQ-028 A sample_valid in the trigger cycle itself SHALL NOT be written.
REQ-029 sample_valid with fifo_full[i]=1 and ch_en_q[i]=1 in CAPTURE SHALL set ovf_err, which remains set until the next accepted arm or reset.
REQ-030 DRAIN: cap_done SHALL be 1 and wr_en SHALL be 0.
REQ-031 DRAIN: when (fifo_empty AND ch_en_q) equals ch_en_q, frame_cnt SHALL increment (wrapping from all-ones to 0) and the FSM SHALL go to ARMED if auto_rearm=1, otherwise to IDLE.
REQ-032 cap_done SHALL be 0 in every state except DRAIN.
REQ-033 abort SHALL force IDLE on the next cycle from any state, drive wr_en to 0 immediately, and leave frame_cnt and ovf_err unchanged.
REQ-034 Simultaneous arm and abort SHALL resolve to abort.
REQ-035 Simultaneous sw_trig and a trig_in edge SHALL produce a single trigger.
REQ-036 len_q=1 SHALL produce a one-sample frame.

Reset
REQ-037 rstn=0 SHALL force the state to IDLE and trig_q to 0, and SHALL clear all counters, ch_en_q, len_q and ovf_err.
REQ-038 During reset, wr_en, fifo_rst, cap_done and busy SHALL all be 0.
REQ-039 Reset asserted mid-CAPTURE SHALL take effect on the next edge, with no further writes.

Structure
REQ-040 The state enum, NCH default and CNT_W default SHALL reside in the shared package adc_capture_pkg.
REQ-041 Trigger edge detection SHALL be the sub-module trig_edge_det (inputs clk, rstn, trig_in; output a one-cycle rise pulse).

Verification
REQ-042 Scenario: arm with ch_en=6'h3F and cap_len=8, sw_trig, then continuous sample_valid -> 8 wr_en pulses on all 6 channels, and cap_done rises the cycle after the 8th sample.
REQ-043 Scenario: fifo_full[2]=1 during samples 3-4 -> wr_en[2] is 0 for those samples, ovf_err=1, and the other channels still receive 8 writes.
REQ-044 Scenario: in DRAIN, empty bits set one channel at a time -> the FSM leaves DRAIN only when the last enabled bit sets, and frame_cnt increments by 1.
REQ-045 Scenario: auto_rearm=1 with frame_cnt preset via 65535 frames (or forced) -> frame_cnt wraps to 0, the FSM returns to ARMED, and fifo_rst is not pulsed.
REQ-046 Scenario: abort on sample 4 of 8 -> wr_en goes to 0 the same cycle, the FSM is in IDLE the next cycle, and cap_done is never asserted.
REQ-047 Scenario: arm with cap_len=0 -> the FSM stays in IDLE, busy=0, and ovf_err is unchanged.
